crc: RTL and testbench
======================

CRC -- requirements
Module: crc

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset; takes effect immediately, independent of clk.
REQ-003 data  input  1  serial message bit, sampled on rising clk while active=1; bit 0 of each byte is sent first.
REQ-004 active  input  1  message-framing strobe; high for exactly the message bits, low otherwise.
REQ-005 CRC  output  1  serial CRC result bit, registered; LFSR bit 0 first.
REQ-006 valid  output  1  registered; high during the 8 cycles in which CRC carries result bits.
REQ-007 Parameter SEED, default 8'hD8, meaning LFSR initial/reload value.

Function
REQ-008 The block SHALL hold an 8-bit LFSR l[7:0], a 3-bit output counter and a state register with states IDLE, SHIFT and OUT.
REQ-009 In IDLE, the block SHALL move to SHIFT on the first rising edge with active=1, consuming that edge's data bit.
REQ-010 In SHIFT with active=1, each rising edge SHALL compute fb = data XOR l[0], then update the LFSR as follows:
- l[7]=fb, l[6]=l[7]^fb, l[5]=l[6], l[4]=l[5]
- l[3]=l[4], l[2]=l[3]^fb, l[1]=l[2], l[0]=l[1]
REQ-011 In SHIFT, the first rising edge with active=0 SHALL enter OUT and drive CRC<=l[0], valid<=1, LFSR shift right (l[7]<=0), counter<=1.
REQ-012 In OUT, each edge SHALL drive CRC<=l[0], valid<=1, shift the LFSR right with zero fill, and increment the counter; exactly 8 bits SHALL be emitted on 8 consecutive cycles.
REQ-013 Because CRC and valid are registered together, the first result bit SHALL be present in the same cycle valid first rises.
REQ-014 Collecting the 8 emitted bits as bit0..bit7 SHALL reproduce the LFSR value that existed at the end of SHIFT.
REQ-015 On the edge after the 8th bit, the block SHALL set valid<=0 and CRC<=0, reload the LFSR with SEED, and return to IDLE; consecutive messages need no reset between them.
REQ-016 Outside OUT, valid SHALL be 0 and CRC SHALL be 0.
REQ-017 The block SHALL ignore active and data while in OUT; a message starts only from IDLE.
REQ-018 A message of any length (at least 1 bit) SHALL be supported; active held high indefinitely SHALL keep the block in SHIFT.
REQ-019 valid SHALL be low for at least 1 cycle between consecutive result frames.

Reset
REQ-020 While reset=1, the block SHALL force: LFSR=SEED (8'hD8), counter=0, state=IDLE, valid=0, CRC=0.
REQ-021 Reset asserted mid-SHIFT or mid-OUT SHALL abort the operation immediately, with no further valid pulses.
REQ-022 After reset deasserts, the block SHALL wait in IDLE for active=1.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset pulse, then idle -> valid=0, CRC=0 for all cycles.
- Byte 8'h00 sent LSB-first over 8 active cycles, then active=0 -> valid high for exactly 8 cycles; collected result 8'h14 (bits 0,0,1,0,1,0,0,0).
- Byte 8'h01 -> collected result 8'hBF.
- 10 back-to-back bytes (8'h00, 8'h01, then arbitrary) with no reset between -> each result matches a reference model seeded with 8'hD8 per byte; 8'h00 and 8'h01 give 8'h14 and 8'hBF again.
- Reset asserted on the 4th cycle of OUT -> valid and CRC go to 0 immediately; the next 8'h00 message still yields 8'h14.
- active pulsed during OUT -> ignored; the current 8-bit frame completes unchanged.

Source files
------------

// File: rtl/crc.sv
// Serial CRC-8 engine: LSB-first message in while active, then 8 registered result bits out with valid.
// Result starts the edge after active falls; no backpressure, and active/data are ignored while the result is emitted.
`timescale 1ns/1ps
module crc #(
  parameter logic [7:0] SEED = 8'hD8
) (
  input  logic clk,
  input  logic reset,
  input  logic data,
  input  logic active,
  output logic CRC,
  output logic valid
);

  typedef enum logic [1:0] {IDLE, SHIFT, OUT} state_t;

  state_t     state, state_nxt;
  logic [7:0] lfsr, lfsr_nxt, lfsr_step;
  logic [2:0] cnt, cnt_nxt;
  logic       crc_nxt, valid_nxt, fb;

  assign fb        = data ^ lfsr[0];
  assign lfsr_step = {fb, lfsr[7] ^ fb, lfsr[6], lfsr[5], lfsr[4], lfsr[3] ^ fb, lfsr[2], lfsr[1]};

  always_comb begin
    state_nxt = state;
    lfsr_nxt  = lfsr;
    cnt_nxt   = cnt;
    crc_nxt   = 1'b0;
    valid_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (active) begin
          lfsr_nxt  = lfsr_step;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (active) begin
          lfsr_nxt = lfsr_step;
        end else begin
          crc_nxt   = lfsr[0];
          valid_nxt = 1'b1;
          lfsr_nxt  = {1'b0, lfsr[7:1]};
          cnt_nxt   = 3'd1;
          state_nxt = OUT;
        end
      end
      OUT: begin
        // cnt wraps to 0 once the 8th bit has been launched; that edge closes the frame
        if (cnt != 3'd0) begin
          crc_nxt   = lfsr[0];
          valid_nxt = 1'b1;
          lfsr_nxt  = {1'b0, lfsr[7:1]};
          cnt_nxt   = cnt + 3'd1;
        end else begin
          lfsr_nxt  = SEED;
          state_nxt = IDLE;
        end
      end
      default: begin
        lfsr_nxt  = SEED;
        cnt_nxt   = 3'd0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      lfsr  <= SEED;
      cnt   <= 3'd0;
      CRC   <= 1'b0;
      valid <= 1'b0;
    end else begin
      state <= state_nxt;
      lfsr  <= lfsr_nxt;
      cnt   <= cnt_nxt;
      CRC   <= crc_nxt;
      valid <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_crc.sv
// Bench for crc: randomized and directed messages, expected CRC queued at issue time,
// a negedge monitor reassembles each 8-bit result frame and compares it against the queue.
`timescale 1ns/1ps
module tb_crc;

  logic clk = 1'b0;
  logic reset, data, active;
  logic CRC, valid;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  crc #(.SEED(8'hD8)) dut (
    .clk(clk), .reset(reset), .data(data), .active(active), .CRC(CRC), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reflected CRC-8: shift right, fold in polynomial taps 7,6,2 when the feedback bit is set.
  function automatic logic [7:0] ref_crc(input logic [63:0] v, input int len);
    logic [7:0] l;
    logic       f;
    l = 8'hD8;
    for (int i = 0; i < len; i++) begin
      f = v[i] ^ l[0];
      l = (l >> 1) ^ (f ? 8'hC4 : 8'h00);
    end
    return l;
  endfunction

  task automatic send_bits(input logic [63:0] v, input int len);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      active = 1'b1;
      data   = v[i];
    end
    @(negedge clk);
    active = 1'b0;
    data   = 1'b0;
  endtask

  // Minimum gap (8) lets the next message start on the first IDLE edge.
  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_checked(input logic [63:0] v, input int len, input logic [7:0] exp);
    exp_q.push_back(exp);
    send_bits(v, len);
  endtask

  // Monitor: reassemble frames, check length, idle CRC and scoreboard contents.
  initial begin
    int run;
    logic [7:0] acc;
    run = 0;
    acc = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        run = 0;
        acc = 8'h00;
      end else if (valid) begin
        if (run < 8) acc[run[2:0]] = CRC;
        run++;
        if (run == 8) begin
          if (exp_q.size() == 0) check("unexpected_frame", acc, 32'hFFFF_FFFF);
          else check("frame_value", acc, exp_q.pop_front());
        end
      end else begin
        check("idle_crc_low", CRC, 0);
        if (run != 0) begin
          check("frame_length", run, 8);
          run = 0;
        end
      end
    end
  end

  initial begin
    logic [63:0] v;
    int len;
    reset  = 1'b1;
    active = 1'b0;
    data   = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_valid", valid, 0);
    check("reset_crc", CRC, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("idle_valid_low", valid, 0);
    end

    // Directed bytes
    send_checked(64'h00, 8, 8'h14);
    gap(10);
    send_checked(64'h01, 8, 8'hBF);
    gap(10);

    // Ten back-to-back bytes at minimum spacing
    send_checked(64'h00, 8, 8'h14);
    gap(8);
    send_checked(64'h01, 8, 8'hBF);
    for (int k = 0; k < 8; k++) begin
      gap(8 + (k % 2));
      v = 64'($urandom_range(0, 255));
      send_checked(v, 8, ref_crc(v, 8));
    end
    gap(10);

    // Random lengths including single-bit messages and one long message
    for (int k = 0; k < 8; k++) begin
      v   = {$urandom, $urandom};
      len = (k == 0) ? 1 : (k == 1) ? 60 : $urandom_range(1, 24);
      send_checked(v, len, ref_crc(v, len));
      gap($urandom_range(8, 11));
    end
    gap(4);

    // Reset on the 4th valid cycle aborts the frame; nothing queued for it
    send_bits(64'h00, 8);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_valid", valid, 0);
    check("abort_crc", CRC, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    gap(12);
    send_checked(64'h00, 8, 8'h14);
    gap(10);

    // active toggled mid-result must not disturb the frame
    v = 64'hA5;
    send_checked(v, 8, ref_crc(v, 8));
    @(negedge clk);
    @(negedge clk);
    active = 1'b1;
    data   = 1'b1;
    @(negedge clk);
    data   = 1'b0;
    @(negedge clk);
    active = 1'b0;
    gap(8);
    send_checked(64'h01, 8, 8'hBF);

    gap(20);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
